pio_irq: RTL and testbench
==========================

// Module: pio_irq
// PURPOSE
//  Next-gen memory-mapped GPIO port: per-bit output/direction/pin-mux like the existing PIO, plus
//  2-flop input synchronisers, rising/falling edge detection, sticky W1C capture and a masked,
//  level interrupt. Sits on the Avalon-MM peripheral bus; oMUXSEL drives the pin-mux fabric.
// PARAMETERS
//  pBITS       32  pin count, 1..32
//  pMUX_BITS   2   mux-select bits per pin, 1..4
//  pDEB_BITS   16  debounce prescaler width (used only with PIO_DEBOUNCE_EN)
// PORTS
//  iCLOCK        in   1                 sole clock
//  iRESET        in   1                 asynchronous, active-low reset
//  iADDRESS      in   cADDRESS_BITS     word address, cADDRESS_BITS=$clog2(9+cMUX_WORDS)
//  iWRITE        in   1                 write strobe
//  iREAD         in   1                 read strobe
//  iWRITE_DATA   in   32                write data
//  oREAD_DATA    out  32                registered read data
//  iPIO          in   pBITS             asynchronous pin inputs
//  oPIO          out  pBITS             pin output values
//  oDIR          out  pBITS             1 = output enable
//  oMUXSEL       out  pBITS*pMUX_BITS   pin-mux selects, pin n at [n*pMUX_BITS +: pMUX_BITS]
//  oIRQ          out  1                 level interrupt = |(CAPTURE & IRQ_MASK)
// BEHAVIOUR
//  Reset (iRESET=0, async): oPIO, oDIR, oMUXSEL, oREAD_DATA, MASK, RISE, FALL, CAPTURE, syncs = 0;
//   oIRQ=0. Release is synchronous to iCLOCK through the internal flops.
//  cMUX_WORDS=(pBITS*pMUX_BITS+31)/32. Map (word): 0 DATA, 1 DIR, 2 CLR, 3 SET, 4 MASK, 5 RISE,
//   6 FALL, 7 CAPTURE, 8 DEBDIV, 9..8+cMUX_WORDS MUXSEL words (LSW first).
//  Writes take effect the cycle after iWRITE: 0 oPIO<=d; 1 oDIR<=d; 2 oPIO<=oPIO&~d; 3 oPIO<=oPIO|d;
//   4/5/6 load; 7 CAPTURE<=CAPTURE&~d (W1C); 8 DEBDIV<=d[pDEB_BITS-1:0]; mux words load 32 bits,
//   last word loads only pBITS*pMUX_BITS%32 LSBs when partial. Bits above pBITS ignored.
//  Reads: oREAD_DATA valid 1 cycle after iREAD, held until next iREAD. 0 returns synced input
//   (sIN), 2/3 return oPIO, others return register; unimplemented bits and addresses read 0.
//  Input path: sIN = 2-flop sync of iPIO (2-cycle latency); prev = sIN delayed 1 cycle.
//   rise = sIN&~prev&RISE, fall = ~sIN&prev&FALL; CAPTURE |= rise|fall each cycle.
//  Simultaneous edge and W1C on same bit: set wins (bit stays 1). Edge detection runs
//   regardless of oDIR (output pins loop back through iPIO).
//  oIRQ registered: asserts 1 cycle after CAPTURE/MASK change; deasserts same way.
//  iREAD and iWRITE same cycle: both serviced; read returns pre-write value.
//  No FSM beyond pipelines; no bus wait states.
// CONFIGURATION
//  PIO_DEBOUNCE_EN defined: pDEB_BITS prescaler counts to DEBDIV then emits 1-cycle tick and
//   reloads 0; per pin, sIN is sampled on each tick into a 3-deep shift; filtered value changes
//   only when all 3 samples agree; edge detect and DATA read use the filtered value.
//   DEBDIV=0 bypasses filter (filtered=sIN). Reset of prescaler/shifts = 0.
//  Undefined: no prescaler/filter logic; DEBDIV writes ignored, reads 0; edges on sIN directly.
// STRUCTURE
//  Package pio_pkg: register address localparams (PIO_A_DATA..PIO_A_MUX0), cMUX_WORDS function,
//   pin-count limit constant.
//  Sub-module pio_in_filter: synchroniser + optional debounce + prev-stage for pBITS pins;
//   outputs filtered level and rise/fall vectors. Top holds registers, decoder, IRQ.
// TESTING
//  1 Write 0xA5 to DIR, 0x0F to DATA, 0x03 to CLR, 0x30 to SET -> oPIO=0x3C, oDIR=0xA5, read 2=0x3C.
//  2 RISE=0x1, MASK=0x1, drive iPIO[0] 0->1 -> CAPTURE[0]=1 at cycle 3, oIRQ=1 at cycle 4;
//     write 0x1 to CAPTURE -> oIRQ=0 two cycles later.
//  3 FALL=0x2, pulse iPIO[1] low while writing W1C 0x2 in the edge cycle -> CAPTURE[1] stays 1.
//  4 pBITS=20,pMUX_BITS=2: write 0xFFFFFFFF to words 9,10 -> oMUXSEL=40'hFF_FFFF_FFFF, read 10=0xFF.
//  5 PIO_DEBOUNCE_EN, DEBDIV=3: 1-tick glitch on iPIO[2] -> no CAPTURE; held 3 ticks -> captured.
//  6 Assert iRESET mid-traffic with CAPTURE=0xFF -> all outputs 0 immediately, oIRQ=0.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants for the pio_irq GPIO port: register word map, pin limits
// and the mux-word count helper.
package pio_pkg;

    localparam int PIO_A_DATA    = 0;
    localparam int PIO_A_DIR     = 1;
    localparam int PIO_A_CLR     = 2;
    localparam int PIO_A_SET     = 3;
    localparam int PIO_A_MASK    = 4;
    localparam int PIO_A_RISE    = 5;
    localparam int PIO_A_FALL    = 6;
    localparam int PIO_A_CAPTURE = 7;
    localparam int PIO_A_DEBDIV  = 8;
    localparam int PIO_A_MUX0    = 9;

    localparam int PIO_MAX_BITS     = 32;
    localparam int PIO_MAX_MUX_BITS = 4;

    // Number of 32-bit bus words needed to hold every pin's mux select.
    function automatic int pio_mux_words(input int bits, input int mux_bits);
        return (bits * mux_bits + 31) / 32;
    endfunction

endpackage

// File: rtl/pio_in_filter.sv
// Pin input path: 2-flop synchroniser, optional debounce filter (PIO_DEBOUNCE_EN),
// and a one-cycle history stage producing raw rising/falling edge vectors.
module pio_in_filter #(
    parameter int pBITS = 32
`ifdef PIO_DEBOUNCE_EN
    ,
    parameter int pDEB_BITS = 16
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [pBITS-1:0] i_pin,
`ifdef PIO_DEBOUNCE_EN
    input  logic [pDEB_BITS-1:0] i_debdiv,
`endif
    output logic [pBITS-1:0] o_level,
    output logic [pBITS-1:0] o_rise,
    output logic [pBITS-1:0] o_fall
);

    logic [pBITS-1:0] r_sync1;
    logic [pBITS-1:0] r_sync2;
    logic [pBITS-1:0] r_prev;
    logic [pBITS-1:0] w_level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    logic [pDEB_BITS-1:0] r_div_cnt;
    logic                 w_tick;
    logic [pBITS-1:0]     r_sh0;
    logic [pBITS-1:0]     r_sh1;
    logic [pBITS-1:0]     r_sh2;
    logic [pBITS-1:0]     r_filt;

    // >= rather than == so lowering DEBDIV below the running count cannot stall ticks.
    assign w_tick = (r_div_cnt >= i_debdiv);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt <= '0;
            r_sh0     <= '0;
            r_sh1     <= '0;
            r_sh2     <= '0;
            r_filt    <= '0;
        end else begin
            if (w_tick) begin
                r_div_cnt <= '0;
                r_sh0     <= r_sync2;
                r_sh1     <= r_sh0;
                r_sh2     <= r_sh1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            r_filt <= (r_filt | (r_sh0 & r_sh1 & r_sh2)) & (r_sh0 | r_sh1 | r_sh2);
        end
    end

    assign w_level = (i_debdiv == '0) ? r_sync2 : r_filt;
`else
    assign w_level = r_sync2;
`endif

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;
    assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/pio_irq.sv
// Memory-mapped GPIO port with pin-mux selects, edge capture and masked level IRQ.
// Define PIO_DEBOUNCE_EN to add the DEBDIV prescaler and per-pin debounce filter.
module pio_irq
    import pio_pkg::*;
#(
    parameter int pBITS     = 32,
    parameter int pMUX_BITS = 2,
    parameter int pDEB_BITS = 16,
    localparam int cMUX_WORDS    = pio_mux_words(pBITS, pMUX_BITS),
    localparam int cADDRESS_BITS = $clog2(9 + cMUX_WORDS)
) (
    input  logic                       iCLOCK,
    input  logic                       iRESET,
    input  logic [cADDRESS_BITS-1:0]   iADDRESS,
    input  logic                       iWRITE,
    input  logic                       iREAD,
    input  logic [31:0]                iWRITE_DATA,
    output logic [31:0]                oREAD_DATA,
    input  logic [pBITS-1:0]           iPIO,
    output logic [pBITS-1:0]           oPIO,
    output logic [pBITS-1:0]           oDIR,
    output logic [pBITS*pMUX_BITS-1:0] oMUXSEL,
    output logic                       oIRQ
);

    localparam int cMUX_TOT = pBITS * pMUX_BITS;
    localparam int cMUX_PAD = cMUX_WORDS * 32;

    if (pBITS < 1 || pBITS > PIO_MAX_BITS || pMUX_BITS < 1 || pMUX_BITS > PIO_MAX_MUX_BITS ||
        pDEB_BITS < 1 || pDEB_BITS > 32) begin : g_param_check
        $error("pio_irq: parameter out of range");
    end

    logic [pBITS-1:0]    r_pio;
    logic [pBITS-1:0]    r_dir;
    logic [pBITS-1:0]    r_mask;
    logic [pBITS-1:0]    r_rise;
    logic [pBITS-1:0]    r_fall;
    logic [pBITS-1:0]    r_capture;
    logic [cMUX_TOT-1:0] r_mux;
    logic [31:0]         r_read_data;
    logic                r_irq;

    logic [pBITS-1:0]    w_level;
    logic [pBITS-1:0]    w_rise;
    logic [pBITS-1:0]    w_fall;
    logic [pBITS-1:0]    w_wdata;
    logic [pBITS-1:0]    w_cap_clr;
    logic [cMUX_PAD-1:0] w_mux_pad;
    logic [31:0]         w_rd;
    int                  w_addr;
    logic                w_wr_data;
    logic                w_wr_dir;
    logic                w_wr_clr;
    logic                w_wr_set;
    logic                w_wr_mask;
    logic                w_wr_rise;
    logic                w_wr_fall;
    logic                w_wr_cap;

`ifdef PIO_DEBOUNCE_EN
    logic [pDEB_BITS-1:0] r_debdiv;
`endif

    pio_in_filter #(
        .pBITS    (pBITS)
`ifdef PIO_DEBOUNCE_EN
        ,
        .pDEB_BITS(pDEB_BITS)
`endif
    ) u_in_filter (
        .i_clk   (iCLOCK),
        .i_rst_n (iRESET),
        .i_pin   (iPIO),
`ifdef PIO_DEBOUNCE_EN
        .i_debdiv(r_debdiv),
`endif
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_addr    = int'(iADDRESS);
    assign w_wdata   = iWRITE_DATA[pBITS-1:0];
    assign w_wr_data = iWRITE && (w_addr == PIO_A_DATA);
    assign w_wr_dir  = iWRITE && (w_addr == PIO_A_DIR);
    assign w_wr_clr  = iWRITE && (w_addr == PIO_A_CLR);
    assign w_wr_set  = iWRITE && (w_addr == PIO_A_SET);
    assign w_wr_mask = iWRITE && (w_addr == PIO_A_MASK);
    assign w_wr_rise = iWRITE && (w_addr == PIO_A_RISE);
    assign w_wr_fall = iWRITE && (w_addr == PIO_A_FALL);
    assign w_wr_cap  = iWRITE && (w_addr == PIO_A_CAPTURE);
    assign w_cap_clr = w_wr_cap ? w_wdata : '0;
    assign w_mux_pad = cMUX_PAD'(r_mux);

    always_comb begin
        w_rd = '0;
        case (w_addr)
            PIO_A_DATA:              w_rd = 32'(w_level);
            PIO_A_DIR:               w_rd = 32'(r_dir);
            PIO_A_CLR, PIO_A_SET:    w_rd = 32'(r_pio);
            PIO_A_MASK:              w_rd = 32'(r_mask);
            PIO_A_RISE:              w_rd = 32'(r_rise);
            PIO_A_FALL:              w_rd = 32'(r_fall);
            PIO_A_CAPTURE:           w_rd = 32'(r_capture);
`ifdef PIO_DEBOUNCE_EN
            PIO_A_DEBDIV:            w_rd = 32'(r_debdiv);
`endif
            default: begin
                for (int k = 0; k < cMUX_WORDS; k++) begin
                    if (w_addr == PIO_A_MUX0 + k) begin
                        w_rd = w_mux_pad[k*32 +: 32];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge iRESET) begin
        if (!iRESET) begin
            r_pio       <= '0;
            r_dir       <= '0;
            r_mask      <= '0;
            r_rise      <= '0;
            r_fall      <= '0;
            r_capture   <= '0;
            r_mux       <= '0;
            r_read_data <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_data) begin
                r_pio <= w_wdata;
            end else if (w_wr_clr) begin
                r_pio <= r_pio & ~w_wdata;
            end else if (w_wr_set) begin
                r_pio <= r_pio | w_wdata;
            end
            if (w_wr_dir)  r_dir  <= w_wdata;
            if (w_wr_mask) r_mask <= w_wdata;
            if (w_wr_rise) r_rise <= w_wdata;
            if (w_wr_fall) r_fall <= w_wdata;
            // New edges are OR'd in after the W1C so a same-cycle edge survives the clear.
            r_capture <= (r_capture & ~w_cap_clr) | (w_rise & r_rise) | (w_fall & r_fall);
            r_irq     <= |(r_capture & r_mask);
            for (int b = 0; b < cMUX_TOT; b++) begin
                if (iWRITE && (w_addr == PIO_A_MUX0 + b / 32)) begin
                    r_mux[b] <= iWRITE_DATA[b % 32];
                end
            end
            if (iREAD) r_read_data <= w_rd;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    always_ff @(posedge iCLOCK or negedge iRESET) begin
        if (!iRESET) begin
            r_debdiv <= '0;
        end else if (iWRITE && (w_addr == PIO_A_DEBDIV)) begin
            r_debdiv <= iWRITE_DATA[pDEB_BITS-1:0];
        end
    end
`endif

    assign oPIO       = r_pio;
    assign oDIR       = r_dir;
    assign oMUXSEL    = r_mux;
    assign oREAD_DATA = r_read_data;
    assign oIRQ       = r_irq;

endmodule

// File: tb/tb_pio_irq.sv
// Self-checking bench for pio_irq (20 pins, 2 mux bits) with a history-based reference model.
module tb_pio_irq;

    localparam int NB   = 20;
    localparam int NM   = 2;
    localparam int NMUX = NB * NM;
    localparam int AW   = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   addr;
    logic            we;
    logic            re;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [NB-1:0]   pins;
    logic [NB-1:0]   o_pio;
    logic [NB-1:0]   o_dir;
    logic [NMUX-1:0] o_mux;
    logic            o_irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pio_irq #(.pBITS(NB), .pMUX_BITS(NM), .pDEB_BITS(16)) dut (
        .iCLOCK     (clk),
        .iRESET     (rst_n),
        .iADDRESS   (addr),
        .iWRITE     (we),
        .iREAD      (re),
        .iWRITE_DATA(wdata),
        .oREAD_DATA (rdata),
        .iPIO       (pins),
        .oPIO       (o_pio),
        .oDIR       (o_dir),
        .oMUXSEL    (o_mux),
        .oIRQ       (o_irq)
    );

    // Reference model: register contents plus the history of pin values applied at each edge.
    logic [NB-1:0]   m_pio, m_dir, m_mask, m_rise, m_fall, m_cap;
    logic [NMUX-1:0] m_mux;
    logic [15:0]     m_debdiv;
    logic [31:0]     m_rd;
    logic            m_irq;
    logic [NB-1:0]   hist[$];

    task automatic model_reset();
        m_pio = '0; m_dir = '0; m_mask = '0; m_rise = '0; m_fall = '0; m_cap = '0;
        m_mux = '0; m_debdiv = '0; m_rd = '0; m_irq = 1'b0;
        hist = {NB'(0), NB'(0), NB'(0)};
    endtask

    function automatic logic [31:0] model_read(input int a, input logic [NB-1:0] s_in);
        case (a)
            0:       return 32'(s_in);
            1:       return 32'(m_dir);
            2, 3:    return 32'(m_pio);
            4:       return 32'(m_mask);
            5:       return 32'(m_rise);
            6:       return 32'(m_fall);
            7:       return 32'(m_cap);
`ifdef PIO_DEBOUNCE_EN
            8:       return 32'(m_debdiv);
`endif
            9:       return m_mux[31:0];
            10:      return 32'(m_mux[NMUX-1:32]);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_update();
        logic [NB-1:0] s_in, s_prev, edges, clr;
        int a;
        if (!rst_n) begin
            model_reset();
        end else begin
            a      = int'(addr);
            s_in   = hist[$-1];  // pins applied two edges ago
            s_prev = hist[$-2];  // pins applied three edges ago
            edges  = (s_in & ~s_prev & m_rise) | (~s_in & s_prev & m_fall);
            if (re) m_rd = model_read(a, s_in);
            clr   = (we && a == 7) ? wdata[NB-1:0] : '0;
            m_irq = |(m_cap & m_mask);
            m_cap = (m_cap & ~clr) | edges;
            if (we) begin
                case (a)
                    0:  m_pio = wdata[NB-1:0];
                    1:  m_dir = wdata[NB-1:0];
                    2:  m_pio = m_pio & ~wdata[NB-1:0];
                    3:  m_pio = m_pio | wdata[NB-1:0];
                    4:  m_mask = wdata[NB-1:0];
                    5:  m_rise = wdata[NB-1:0];
                    6:  m_fall = wdata[NB-1:0];
                    8:  m_debdiv = wdata[15:0];
                    9:  m_mux[31:0] = wdata;
                    10: m_mux[NMUX-1:32] = wdata[NMUX-33:0];
                    default: ;
                endcase
            end
            hist.push_back(pins);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) clk_step();
    endtask

    task automatic bus_write(input int a, input logic [31:0] d);
        addr = AW'(a); wdata = d; we = 1'b1;
        clk_step();
        we = 1'b0;
        $display("[TB] WR addr=%0d data=%h", a, d);
    endtask

    task automatic bus_read(input int a);
        addr = AW'(a); re = 1'b1;
        clk_step();
        re = 1'b0;
        $display("[TB] RD addr=%0d data=%h", a, rdata);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; pins = '0;
        model_reset();
        idle(3);
        n_tests++; if (o_pio !== '0)  begin n_fail++; $display("FAIL reset_pio: got %h want 0", o_pio); end
        n_tests++; if (o_dir !== '0)  begin n_fail++; $display("FAIL reset_dir: got %h want 0", o_dir); end
        n_tests++; if (o_mux !== '0)  begin n_fail++; $display("FAIL reset_mux: got %h want 0", o_mux); end
        n_tests++; if (rdata !== '0)  begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", o_irq); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        bus_write(1, 32'hA5);
        bus_write(0, 32'h0F);
        bus_write(2, 32'h03);
        bus_write(3, 32'h30);
        n_tests++; if (o_pio !== 20'h3C) begin n_fail++; $display("FAIL basic_pio: got %h want 3c", o_pio); end
        n_tests++; if (o_dir !== 20'hA5) begin n_fail++; $display("FAIL basic_dir: got %h want a5", o_dir); end
        bus_read(2);
        n_tests++; if (rdata !== 32'h3C) begin n_fail++; $display("FAIL basic_read_clr: got %h want 3c", rdata); end
        bus_read(3);
        n_tests++; if (rdata !== 32'h3C) begin n_fail++; $display("FAIL basic_read_set: got %h want 3c", rdata); end
    endtask

    task automatic test_irq();
        bus_write(5, 32'h1);
        bus_write(4, 32'h1);
        idle(4);
        pins[0] = 1'b1;
        idle(2);
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early2: got %b want 0", o_irq); end
        clk_step();
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_early3: got %b want 0", o_irq); end
        clk_step();
        n_tests++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_cycle4: got %b want 1", o_irq); end
        bus_read(7);
        n_tests++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL irq_capture: got %h want 1", rdata); end
        bus_write(7, 32'h1);
        n_tests++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL irq_clear1: got %b want 1", o_irq); end
        clk_step();
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear2: got %b want 0", o_irq); end
    endtask

    task automatic test_w1c_race();
        bus_write(6, 32'h2);
        pins[1] = 1'b1;
        idle(4);
        bus_write(7, 32'hFFFFF);
        pins[1] = 1'b0;
        idle(2);
        pins[1] = 1'b1;
        bus_write(7, 32'h2);  // W1C lands in the same cycle as the falling edge
        bus_read(7);
        n_tests++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL race_set_wins: got %h want 2", rdata); end
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL race_masked_irq: got %b want 0", o_irq); end
        bus_write(7, 32'h2);
        bus_read(7);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL race_cleared: got %h want 0", rdata); end
    endtask

    task automatic test_mux();
        logic [31:0] exp_deb;
        bus_write(9, 32'hFFFFFFFF);
        bus_write(10, 32'hFFFFFFFF);
        n_tests++; if (o_mux !== 40'hFF_FFFF_FFFF) begin n_fail++; $display("FAIL mux_out: got %h want ffffffffff", o_mux); end
        bus_read(10);
        n_tests++; if (rdata !== 32'hFF) begin n_fail++; $display("FAIL mux_read_hi: got %h want ff", rdata); end
        bus_read(9);
        n_tests++; if (rdata !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mux_read_lo: got %h want ffffffff", rdata); end
        bus_write(1, 32'hFFFFFFFF);
        bus_read(1);
        n_tests++; if (rdata !== 32'h000FFFFF) begin n_fail++; $display("FAIL dir_width: got %h want 000fffff", rdata); end
        bus_read(11);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unimpl_11: got %h want 0", rdata); end
        bus_read(15);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unimpl_15: got %h want 0", rdata); end
        bus_write(8, 32'h12345);
        bus_read(8);
`ifdef PIO_DEBOUNCE_EN
        exp_deb = 32'h2345;
`else
        exp_deb = 32'h0;
`endif
        n_tests++; if (rdata !== exp_deb) begin n_fail++; $display("FAIL debdiv_read: got %h want %h", rdata, exp_deb); end
        bus_write(8, 32'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) pins = NB'($urandom());
            we    = ($urandom_range(2) == 0);
            re    = ($urandom_range(1) == 0);
            addr  = AW'($urandom_range(15));
            wdata = $urandom();
            if (addr == 4'd8) wdata = 32'h0;
            clk_step();
            we = 1'b0; re = 1'b0;
            n_tests++; if (o_pio !== m_pio) begin n_fail++; $display("FAIL rnd_pio[%0d]: got %h want %h", i, o_pio, m_pio); end
            n_tests++; if (o_dir !== m_dir) begin n_fail++; $display("FAIL rnd_dir[%0d]: got %h want %h", i, o_dir, m_dir); end
            n_tests++; if (o_mux !== m_mux) begin n_fail++; $display("FAIL rnd_mux[%0d]: got %h want %h", i, o_mux, m_mux); end
            n_tests++; if (o_irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, o_irq, m_irq); end
            n_tests++; if (rdata !== m_rd)  begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rdata, m_rd); end
        end
        $display("[TB] random phase complete");
    endtask

    task automatic test_back_to_back();
        bus_write(1, 32'h111);
        addr = AW'(1); wdata = 32'h222; we = 1'b1; re = 1'b1;
        clk_step();
        we = 1'b0; re = 1'b0;
        $display("[TB] RD+WR addr=1 data=%h", rdata);
        n_tests++; if (rdata !== 32'h111) begin n_fail++; $display("FAIL b2b_pre_write: got %h want 111", rdata); end
        n_tests++; if (o_dir !== 20'h222) begin n_fail++; $display("FAIL b2b_dir: got %h want 222", o_dir); end
        idle(3);
        n_tests++; if (rdata !== 32'h111) begin n_fail++; $display("FAIL b2b_hold: got %h want 111", rdata); end
        bus_read(1);
        n_tests++; if (rdata !== 32'h222) begin n_fail++; $display("FAIL b2b_post_write: got %h want 222", rdata); end
        bus_write(0, 32'h0);
        bus_write(3, 32'h1);
        bus_write(3, 32'h2);
        n_tests++; if (o_pio !== 20'h3) begin n_fail++; $display("FAIL b2b_set_set: got %h want 3", o_pio); end
    endtask

    task automatic test_debounce();
        bus_write(5, 32'h4);
        bus_write(6, 32'h0);
        pins = '0;
        idle(6);
        bus_write(7, 32'hFFFFF);
`ifdef PIO_DEBOUNCE_EN
        bus_write(8, 32'h3);
        idle(8);
        pins[2] = 1'b1;
        idle(3);
        pins[2] = 1'b0;
        idle(30);
        bus_read(7);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL deb_glitch: got %h want 0", rdata); end
        pins[2] = 1'b1;
        idle(40);
        bus_read(7);
        n_tests++; if (rdata !== 32'h4) begin n_fail++; $display("FAIL deb_held: got %h want 4", rdata); end
        bus_read(0);
        n_tests++; if (rdata !== 32'h4) begin n_fail++; $display("FAIL deb_level: got %h want 4", rdata); end
        bus_write(8, 32'h0);
`else
        pins[2] = 1'b1;
        idle(3);
        pins[2] = 1'b0;
        idle(6);
        bus_read(7);
        n_tests++; if (rdata !== 32'h4) begin n_fail++; $display("FAIL nodeb_glitch: got %h want 4", rdata); end
`endif
    endtask

    task automatic test_reset_mid();
        bus_write(5, 32'hFF);
        bus_write(6, 32'h0);
        bus_write(4, 32'hFF);
        pins = '0;
        idle(6);
        bus_write(7, 32'hFFFFF);
        pins = 20'hFF;
        idle(6);
        bus_write(9, 32'hDEADBEEF);
        bus_read(7);
        n_tests++; if (rdata !== 32'hFF) begin n_fail++; $display("FAIL rst_pre_capture: got %h want ff", rdata); end
        n_tests++; if (o_irq !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq: got %b want 1", o_irq); end
        addr = AW'(0); wdata = 32'h5A5A5; we = 1'b1;
        clk_step();
        #2;
        rst_n = 1'b0;
        #1;
        we = 1'b0;
        n_tests++; if (o_pio !== '0)  begin n_fail++; $display("FAIL rst_mid_pio: got %h want 0", o_pio); end
        n_tests++; if (o_dir !== '0)  begin n_fail++; $display("FAIL rst_mid_dir: got %h want 0", o_dir); end
        n_tests++; if (o_mux !== '0)  begin n_fail++; $display("FAIL rst_mid_mux: got %h want 0", o_mux); end
        n_tests++; if (rdata !== '0)  begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 0", rdata); end
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq: got %b want 0", o_irq); end
        model_reset();
        idle(2);
        rst_n = 1'b1;
        idle(4);
        bus_read(7);
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_post_capture: got %h want 0", rdata); end
        n_tests++; if (o_irq !== 1'b0) begin n_fail++; $display("FAIL rst_post_irq: got %b want 0", o_irq); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_irq();
        test_w1c_race();
        test_mux();
        test_random();
        test_back_to_back();
        test_debounce();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
